// File: rtl/jtdsp16_cache.sv
// Instruction cache and loop sequencer for the DSP16 `do K {} N` / `redo N` forms.
// The first pass forwards and captures ROM words; later passes replay them with the PC frozen.
module jtdsp16_cache #(
    parameter int unsigned DEPTH = 15,
    parameter int unsigned IW    = 16,
    parameter int unsigned NW    = 7,
    parameter int unsigned KW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          do_start,
    input  logic          redo_start,
    input  logic [KW-1:0] k_in,
    input  logic [NW-1:0] n_in,
    input  logic [IW-1:0] rom_din,
    input  logic          rom_valid,
    output logic [IW-1:0] ins_out,
    output logic          ins_valid,
    output logic          from_cache,
    output logic          pc_halt,
    output logic          busy,
    output logic          loop_done,
    output logic          cerr,
    output logic [NW-1:0] cloop
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [KW-1:0] K_ONE = KW'(1);
    localparam logic [NW-1:0] N_ONE = NW'(1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        LOOP
    } state_t;

    state_t        state, state_nxt;
    logic [KW-1:0] k_q, k_nxt;
    logic [NW-1:0] n_q, n_nxt;
    logic [KW-1:0] wr_ptr, wr_nxt;
    logic [KW-1:0] rd_ptr, rd_nxt;
    logic [NW-1:0] cloop_nxt;
    logic          cache_valid, cache_valid_nxt;
    logic          mem_we;
    logic [KW-1:0] k_last;
    logic          do_bad;
    logic          redo_bad;

    logic [IW-1:0] mem [DEPTH];

    // Distributed RAM: synchronous write, asynchronous read, contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[AW'(wr_ptr)] <= rom_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            k_q         <= '0;
            n_q         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cloop       <= '0;
            cache_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            k_q         <= k_nxt;
            n_q         <= n_nxt;
            wr_ptr      <= wr_nxt;
            rd_ptr      <= rd_nxt;
            cloop       <= cloop_nxt;
            cache_valid <= cache_valid_nxt;
        end
    end

    assign k_last   = k_q - K_ONE;
    assign do_bad   = (k_in == '0) || (k_in > KW'(DEPTH)) || (n_in == '0);
    assign redo_bad = !cache_valid || (n_in == '0);

    // Next-state and datapath steering
    always_comb begin
        state_nxt       = state;
        k_nxt           = k_q;
        n_nxt           = n_q;
        wr_nxt          = wr_ptr;
        rd_nxt          = rd_ptr;
        cloop_nxt       = cloop;
        cache_valid_nxt = cache_valid;
        mem_we          = 1'b0;
        ins_out         = rom_din;
        ins_valid       = rom_valid;
        from_cache      = 1'b0;
        pc_halt         = 1'b0;
        busy            = 1'b0;
        loop_done       = 1'b0;
        cerr            = 1'b0;

        case (state)
            IDLE: begin
                if (cen) begin
                    // do has priority over a simultaneous redo
                    if (do_start) begin
                        if (do_bad) begin
                            cerr = 1'b1;
                        end else begin
                            k_nxt           = k_in;
                            n_nxt           = n_in;
                            wr_nxt          = '0;
                            cache_valid_nxt = 1'b0;
                            state_nxt       = FILL;
                        end
                    end else if (redo_start) begin
                        if (redo_bad) begin
                            cerr = 1'b1;
                        end else begin
                            cloop_nxt = n_in;
                            rd_nxt    = '0;
                            state_nxt = LOOP;
                        end
                    end
                end
            end

            FILL: begin
                busy = 1'b1;
                if (cen && rom_valid) begin
                    mem_we = 1'b1;
                    wr_nxt = wr_ptr + K_ONE;
                    if (wr_ptr == k_last) begin
                        cache_valid_nxt = 1'b1;
                        cloop_nxt       = n_q - N_ONE;
                        rd_nxt          = '0;
                        if (n_q == N_ONE) begin
                            loop_done = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = LOOP;
                        end
                    end
                end
            end

            LOOP: begin
                busy       = 1'b1;
                pc_halt    = 1'b1;
                from_cache = 1'b1;
                ins_out    = mem[AW'(rd_ptr)];
                ins_valid  = 1'b1;
                if (cen) begin
                    if (rd_ptr == k_last) begin
                        rd_nxt    = '0;
                        cloop_nxt = cloop - N_ONE;
                        if (cloop == N_ONE) begin
                            loop_done = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        rd_nxt = rd_ptr + K_ONE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
